// File: rtl/decode_exec_unit_if.sv
// rtl/decode_exec_unit_if.sv - instruction/operand inputs and decoded/ALU outputs of decode_exec_unit
interface decode_exec_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 12
);
  logic [31:0]     I_instr;
  logic [AW-1:0]   I_pc;
  logic [XLEN-1:0] I_dataA;
  logic [XLEN-1:0] I_dataB;
  logic            O_enpc;
  logic            O_enmem;
  logic            O_endec;
  logic            O_enrg;
  logic            O_enalu;
  logic [6:0]      O_op;
  logic [4:0]      O_rs1;
  logic [4:0]      O_rs2;
  logic [4:0]      O_rd;
  logic [2:0]      O_funct3;
  logic [6:0]      O_funct7;
  logic [XLEN-1:0] O_imm;
  logic            O_mread2;
  logic            O_load2;
  logic [XLEN-1:0] intr_result;
  logic [AW-1:0]   O_addr;
  logic            B;
  logic            O_read2;

  modport master (
    output I_instr, I_pc, I_dataA, I_dataB,
    input  O_enpc, O_enmem, O_endec, O_enrg, O_enalu,
    input  O_op, O_rs1, O_rs2, O_rd, O_funct3, O_funct7, O_imm,
    input  O_mread2, O_load2, intr_result, O_addr, B, O_read2
  );

  modport slave (
    input  I_instr, I_pc, I_dataA, I_dataB,
    output O_enpc, O_enmem, O_endec, O_enrg, O_enalu,
    output O_op, O_rs1, O_rs2, O_rd, O_funct3, O_funct7, O_imm,
    output O_mread2, O_load2, intr_result, O_addr, B, O_read2
  );
endinterface

// File: rtl/decode_exec_unit.sv
// rtl/decode_exec_unit.sv - multi-cycle RV32I slice: stage sequencer, decoder and ALU
module decode_exec_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 12
) (
  input logic                 clk,
  input logic                 I_reset,
  decode_exec_unit_if.slave   bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    S_IDLE, S_PC, S_MEM, S_DEC, S_REG, S_ALU
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_enpc, w_enmem, w_endec, w_enrg, w_enalu;

  always_ff @(posedge clk or posedge I_reset) begin
    if (I_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_enpc  = 1'b0;
    w_enmem = 1'b0;
    w_endec = 1'b0;
    w_enrg  = 1'b0;
    w_enalu = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_PC;
      S_PC:   begin w_enpc  = 1'b1; w_next = S_MEM; end
      S_MEM:  begin w_enmem = 1'b1; w_next = S_DEC; end
      S_DEC:  begin w_endec = 1'b1; w_next = S_REG; end
      S_REG:  begin w_enrg  = 1'b1; w_next = S_ALU; end
      S_ALU:  begin w_enalu = 1'b1; w_next = S_PC;  end
      default: w_next = S_IDLE;
    endcase
  end

  logic [31:0]     w_ins;
  logic [6:0]      w_op;
  logic [XLEN-1:0] w_imm;

  assign w_ins = bus.I_instr;
  assign w_op  = w_ins[6:0];

  always_comb begin
    w_imm = '0;
    case (w_op)
      OP_I, OP_LD, OP_JALR: w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
      OP_ST:                w_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      OP_BR:                w_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25],
                                     w_ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:     w_imm = {w_ins[31:12], 12'b0};
      OP_JAL:               w_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20],
                                     w_ins[30:21], 1'b0};
      default:              w_imm = '0;
    endcase
  end

  logic [6:0]      r_op;
  logic [4:0]      r_rd, r_rs1, r_rs2;
  logic [2:0]      r_f3;
  logic [6:0]      r_f7;
  logic [XLEN-1:0] r_imm;
  logic            r_mread2, r_load2;

  always_ff @(posedge clk or posedge I_reset) begin
    if (I_reset) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_f3     <= '0;
      r_f7     <= '0;
      r_imm    <= '0;
      r_mread2 <= 1'b0;
      r_load2  <= 1'b0;
    end else if (r_state == S_DEC) begin
      r_op     <= w_op;
      r_rd     <= w_ins[11:7];
      r_f3     <= w_ins[14:12];
      r_rs1    <= w_ins[19:15];
      r_rs2    <= w_ins[24:20];
      r_f7     <= w_ins[31:25];
      r_imm    <= w_imm;
      r_mread2 <= (w_op == OP_LD);
      r_load2  <= (w_op == OP_R) || (w_op == OP_I) || (w_op == OP_LUI) ||
                  (w_op == OP_AUIPC) || (w_op == OP_JAL) || (w_op == OP_JALR);
    end
  end

  logic [XLEN-1:0] w_a, w_b, w_pc32, w_op2, w_alu, w_res;
  logic [4:0]      w_sh;
  logic [AW-1:0]   w_addr;
  logic            w_cond, w_taken, w_store;

  assign w_a    = bus.I_dataA;
  assign w_b    = bus.I_dataB;
  assign w_pc32 = XLEN'(bus.I_pc);
  assign w_op2  = (r_op == OP_R) ? w_b : r_imm;
  assign w_sh   = w_op2[4:0];

  // SUB only exists in the register form; f7[5] of an I-type selects SRAI only
  always_comb begin
    w_alu = '0;
    case (r_f3)
      3'b000: w_alu = (r_op == OP_R && r_f7[5]) ? (w_a - w_op2) : (w_a + w_op2);
      3'b001: w_alu = w_a << w_sh;
      3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_op2))};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, (w_a < w_op2)};
      3'b100: w_alu = w_a ^ w_op2;
      3'b101: w_alu = r_f7[5] ? XLEN'($signed(w_a) >>> w_sh) : (w_a >> w_sh);
      3'b110: w_alu = w_a | w_op2;
      3'b111: w_alu = w_a & w_op2;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (r_f3)
      3'b000: w_cond = (w_a == w_b);
      3'b001: w_cond = (w_a != w_b);
      3'b100: w_cond = ($signed(w_a) <  $signed(w_b));
      3'b101: w_cond = ($signed(w_a) >= $signed(w_b));
      3'b110: w_cond = (w_a <  w_b);
      3'b111: w_cond = (w_a >= w_b);
      default: w_cond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] r_result;
  logic [AW-1:0]   r_addr;
  logic            r_b, r_read2;

  always_comb begin
    w_res   = r_result;
    w_addr  = r_addr;
    w_taken = 1'b0;
    w_store = 1'b0;
    case (r_op)
      OP_R, OP_I: w_res = w_alu;
      OP_LUI:     w_res = r_imm;
      OP_AUIPC:   w_res = w_pc32 + r_imm;
      OP_JAL: begin
        w_res   = w_pc32 + XLEN'(4);
        w_addr  = AW'(w_pc32 + r_imm);
        w_taken = 1'b1;
      end
      OP_JALR: begin
        w_res   = w_pc32 + XLEN'(4);
        w_addr  = AW'((w_a + r_imm) & ~XLEN'(1));
        w_taken = 1'b1;
      end
      OP_BR: begin
        w_res   = '0;
        w_addr  = AW'(w_pc32 + r_imm);
        w_taken = w_cond;
      end
      OP_LD: w_addr = AW'(w_a + r_imm);
      OP_ST: begin
        w_addr  = AW'(w_a + r_imm);
        w_res   = w_b;
        w_store = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge I_reset) begin
    if (I_reset) begin
      r_result <= '0;
      r_addr   <= '0;
      r_b      <= 1'b0;
      r_read2  <= 1'b0;
    end else if (r_state == S_ALU) begin
      r_result <= w_res;
      r_addr   <= w_addr;
      r_b      <= w_taken;
      r_read2  <= w_store;
    end
  end

  assign bus.O_enpc      = w_enpc;
  assign bus.O_enmem     = w_enmem;
  assign bus.O_endec     = w_endec;
  assign bus.O_enrg      = w_enrg;
  assign bus.O_enalu     = w_enalu;
  assign bus.O_op        = r_op;
  assign bus.O_rs1       = r_rs1;
  assign bus.O_rs2       = r_rs2;
  assign bus.O_rd        = r_rd;
  assign bus.O_funct3    = r_f3;
  assign bus.O_funct7    = r_f7;
  assign bus.O_imm       = r_imm;
  assign bus.O_mread2    = r_mread2;
  assign bus.O_load2     = r_load2;
  assign bus.intr_result = r_result;
  assign bus.O_addr      = r_addr;
  assign bus.B           = r_b;
  assign bus.O_read2     = r_read2;

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb/tb_decode_exec_unit.sv - randomized bench for decode_exec_unit against a behavioural model
module tb_decode_exec_unit;

  logic clk = 1'b0;
  logic I_reset = 1'b1;
  always #5 clk = ~clk;

  decode_exec_unit_if #(.XLEN(32), .AW(12)) bus ();
  decode_exec_unit #(.XLEN(32), .AW(12)) dut (.clk(clk), .I_reset(I_reset), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        mread2, load2;
  } dec_t;

  typedef struct {
    logic [31:0] res;
    logic [11:0] addr;
    logic        tk, st;
  } alu_t;

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return (v[bits-1]) ? (v | (32'hFFFF_FFFF << bits)) : v;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i);
    logic [31:0] v;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return sext(32'(i[31:20]), 12);
      7'h23: return sext(32'({i[31:25], i[11:7]}), 12);
      7'h63: begin v = 32'({i[31], i[7], i[30:25], i[11:8]}) * 2; return sext(v, 13); end
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: begin v = 32'({i[31], i[19:12], i[20], i[30:21]}) * 2; return sext(v, 21); end
      default: return 32'd0;
    endcase
  endfunction

  function automatic dec_t model_dec(input logic [31:0] i);
    dec_t d;
    d.op = i[6:0]; d.rd = i[11:7]; d.f3 = i[14:12];
    d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.f7 = i[31:25];
    d.imm = model_imm(i);
    d.mread2 = (d.op == 7'h03);
    d.load2 = d.op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67};
    return d;
  endfunction

  function automatic alu_t model_alu(input logic [31:0] i, input logic [11:0] pc,
                                     input logic [31:0] a, input logic [31:0] b, input alu_t prev);
    alu_t r;
    logic [31:0] imm, y, pcw;
    int sh;
    r = prev; r.tk = 1'b0; r.st = 1'b0;
    imm = model_imm(i);
    pcw = 32'(pc);
    case (i[6:0])
      7'h33, 7'h13: begin
        y  = (i[6:0] == 7'h33) ? b : imm;
        sh = int'(y % 32);
        case (i[14:12])
          3'd0: r.res = (i[6:0] == 7'h33 && i[30]) ? a - y : a + y;
          3'd1: r.res = a << sh;
          3'd2: r.res = (int'(a) < int'(y)) ? 32'd1 : 32'd0;
          3'd3: r.res = (a < y) ? 32'd1 : 32'd0;
          3'd4: r.res = a ^ y;
          3'd5: r.res = (a >> sh) | ((i[30] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
          3'd6: r.res = a | y;
          default: r.res = a & y;
        endcase
      end
      7'h37: r.res = imm;
      7'h17: r.res = pcw + imm;
      7'h6F: begin r.res = pcw + 4; r.addr = 12'(pcw + imm); r.tk = 1'b1; end
      7'h67: begin r.res = pcw + 4; r.addr = 12'((a + imm) & 32'hFFFF_FFFE); r.tk = 1'b1; end
      7'h63: begin
        r.res = 32'd0;
        r.addr = 12'(pcw + imm);
        case (i[14:12])
          3'd0: r.tk = (a == b);
          3'd1: r.tk = (a != b);
          3'd4: r.tk = (int'(a) <  int'(b));
          3'd5: r.tk = (int'(a) >= int'(b));
          3'd6: r.tk = (a <  b);
          3'd7: r.tk = (a >= b);
          default: r.tk = 1'b0;
        endcase
      end
      7'h03: r.addr = 12'(a + imm);
      7'h23: begin r.addr = 12'(a + imm); r.res = b; r.st = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  int n = 0;
  always @(posedge clk or posedge I_reset) begin
    if (I_reset) n <= 0;
    else         n <= n + 1;
  end

  dec_t        mf = '{default: '0};
  alu_t        ma = '{default: '0};
  logic [31:0] dec_ins = '0;

  // single compare process: stage enables, decoded fields and ALU outputs every cycle
  always @(negedge clk) begin
    int es;
    if (I_reset) begin
      mf = '{default: '0};
      ma = '{default: '0};
      es = -1;
    end else begin
      es = (n == 0) ? -1 : (n - 1) % 5;
    end
    check("enpc",  32'(bus.O_enpc),  32'(es == 0));
    check("enmem", 32'(bus.O_enmem), 32'(es == 1));
    check("endec", 32'(bus.O_endec), 32'(es == 2));
    check("enrg",  32'(bus.O_enrg),  32'(es == 3));
    check("enalu", 32'(bus.O_enalu), 32'(es == 4));
    check("op",    32'(bus.O_op),     32'(mf.op));
    check("rd",    32'(bus.O_rd),     32'(mf.rd));
    check("rs1",   32'(bus.O_rs1),    32'(mf.rs1));
    check("rs2",   32'(bus.O_rs2),    32'(mf.rs2));
    check("funct3",32'(bus.O_funct3), 32'(mf.f3));
    check("funct7",32'(bus.O_funct7), 32'(mf.f7));
    check("imm",   bus.O_imm,         mf.imm);
    check("mread2",32'(bus.O_mread2), 32'(mf.mread2));
    check("load2", 32'(bus.O_load2),  32'(mf.load2));
    check("result",bus.intr_result,   ma.res);
    check("addr",  32'(bus.O_addr),   32'(ma.addr));
    check("taken", 32'(bus.B),        32'(ma.tk));
    check("read2", 32'(bus.O_read2),  32'(ma.st));
    if (es == 2) begin
      dec_ins = bus.I_instr;
      mf = model_dec(bus.I_instr);
    end
    if (es == 4) ma = model_alu(dec_ins, bus.I_pc, bus.I_dataA, bus.I_dataB, ma);
  end

  // called one time unit after the edge entering PC; returns one unit after the next such edge
  task automatic run_instr(input logic [31:0] ins, input logic [11:0] pc,
                           input logic [31:0] a, input logic [31:0] b);
    bus.I_instr = ins;
    bus.I_pc    = pc;
    bus.I_dataA = a;
    bus.I_dataB = b;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int count);
    logic [6:0]  ops [10];
    logic [31:0] r, a, b;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    for (int k = 0; k < count; k++) begin
      r = $urandom();
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 7) == 0) r[7] = 1'b1;
      run_instr({r[31:7], ops[$urandom_range(0, 9)]}, 12'($urandom()), a, b);
    end
  endtask

  task automatic release_reset;
    @(negedge clk); #1;
    I_reset = 1'b0;
    check("idle_result", bus.intr_result, 32'd0);
    check("idle_enpc", 32'(bus.O_enpc), 32'd0);
    @(posedge clk); #1;
    check("first_enpc", 32'(bus.O_enpc), 32'd1);
  endtask

  initial begin
    bus.I_instr = '0;
    bus.I_pc    = '0;
    bus.I_dataA = '0;
    bus.I_dataB = '0;
    I_reset = 1'b1;
    repeat (3) @(posedge clk);
    release_reset();

    run_instr(32'h0050_0093, 12'h000, 32'd0, 32'd0);
    check("addi_result", bus.intr_result, 32'd5);
    check("addi_rd", 32'(bus.O_rd), 32'd1);
    check("addi_imm", bus.O_imm, 32'd5);
    check("addi_load2", 32'(bus.O_load2), 32'd1);
    check("addi_taken", 32'(bus.B), 32'd0);

    run_instr(32'h4020_8033, 12'h004, 32'd10, 32'd3);
    check("sub_pos", bus.intr_result, 32'd7);
    run_instr(32'h4020_8033, 12'h008, 32'd3, 32'd10);
    check("sub_neg", bus.intr_result, 32'hFFFF_FFF9);

    run_instr(32'h0020_8463, 12'h010, 32'd7, 32'd7);
    check("beq_taken", 32'(bus.B), 32'd1);
    check("beq_addr", 32'(bus.O_addr), 32'h018);
    run_instr(32'h0020_8463, 12'h010, 32'd7, 32'd8);
    check("beq_not_taken", 32'(bus.B), 32'd0);

    run_instr(32'h4040_D193, 12'h014, 32'h8000_0000, 32'd0);
    check("srai", bus.intr_result, 32'hF800_0000);
    run_instr(32'h0020_A223, 12'h018, 32'h100, 32'hDEAD_BEEF);
    check("sw_addr", 32'(bus.O_addr), 32'h104);
    check("sw_read2", 32'(bus.O_read2), 32'd1);

    run_random(300);

    bus.I_instr = 32'h0050_0093;
    @(posedge clk);
    @(posedge clk); #2;
    I_reset = 1'b1;
    #1;
    check("async_enalu", 32'(bus.O_enalu), 32'd0);
    check("async_endec", 32'(bus.O_endec), 32'd0);
    check("async_result", bus.intr_result, 32'd0);
    check("async_op", 32'(bus.O_op), 32'd0);
    check("async_taken", 32'(bus.B), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();

    run_random(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
